// File: rtl/input_debounce_pkg.sv
`default_nettype none
// ============================================================================
// Module      : input_debounce_pkg
// Description : Shared constants and helpers for the input_debounce block.
//               - DEBOUNCE_10MS_100MHZ : 10 ms qualification time at 100 MHz.
//               - cnt_width()          : width of the per-channel stable-level
//                                        counter for a given STABLE_CYCLES.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package input_debounce_pkg;

   localparam int DEBOUNCE_10MS_100MHZ = 1_000_000;

   // The counter has to hold 0 .. STABLE_CYCLES-1. Sizing it to hold
   // STABLE_CYCLES itself keeps the width at least 1 for STABLE_CYCLES = 1.
   function automatic int cnt_width(input int stable_cycles);
      return (stable_cycles < 1) ? 1 : $clog2(stable_cycles + 1);
   endfunction

endpackage : input_debounce_pkg
`default_nettype wire

// File: rtl/input_debounce_chan.sv
`default_nettype none
// ============================================================================
// Module      : debounce_chan
// Description : One debounce channel. Two-flop synchronizer, stable-level
//               counter, registered debounced output and optional single-cycle
//               rise/fall pulses coincident with the output transition.
// Ports       : clk     - system clock
//               a_reset - asynchronous active-high reset
//               din     - raw pin level, asynchronous to clk
//               dout    - debounced level
//               rise    - one-cycle pulse when dout goes 0->1
//               fall    - one-cycle pulse when dout goes 1->0
// Macro       : INPUT_DEBOUNCE_EDGE_EN - builds the rise/fall registers; when
//               undefined rise/fall are tied to 0.
// Revision    : 1.0 - initial release
// ============================================================================
module debounce_chan
   import input_debounce_pkg::*;
#(
   parameter int   STABLE_CYCLES = DEBOUNCE_10MS_100MHZ,
   parameter logic RESET_VAL     = 1'b0
) (
   input  logic clk,
   input  logic a_reset,
   input  logic din,
   output logic dout,
   output logic rise,
   output logic fall
);

   localparam int                 c_cnt_w    = cnt_width(STABLE_CYCLES);
   localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(STABLE_CYCLES - 1);
   localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

   logic               r_s1;
   logic               r_s2;
   logic               r_dout;
   logic [c_cnt_w-1:0] r_cnt;

   logic               w_differ;
   logic               w_accept;
   logic [c_cnt_w-1:0] w_cnt_next;

   // Any cycle where the synchronized level agrees with dout restarts the
   // qualification, so only an unbroken run of STABLE_CYCLES differing
   // samples is accepted. Acceptance and counting are mutually exclusive,
   // which keeps the counter from ever passing c_cnt_last.
   always_comb begin
      w_differ   = (r_s2 != r_dout);
      w_accept   = w_differ && (r_cnt == c_cnt_last);
      w_cnt_next = '0;
      if (w_differ && !w_accept) begin
         w_cnt_next = r_cnt + c_cnt_one;
      end
   end

   always_ff @(posedge clk or posedge a_reset) begin
      if (a_reset) begin
         r_s1   <= RESET_VAL;
         r_s2   <= RESET_VAL;
         r_dout <= RESET_VAL;
         r_cnt  <= '0;
      end else begin
         r_s1  <= din;
         r_s2  <= r_s1;
         r_cnt <= w_cnt_next;
         if (w_accept) begin
            r_dout <= r_s2;
         end
      end
   end

   assign dout = r_dout;

`ifdef INPUT_DEBOUNCE_EDGE_EN
   logic r_rise;
   logic r_fall;

   // Registered from the same acceptance term that loads dout, so each pulse
   // lines up with the dout transition cycle and lasts exactly one cycle
   // (the counter restarts at 0 after acceptance).
   always_ff @(posedge clk or posedge a_reset) begin
      if (a_reset) begin
         r_rise <= 1'b0;
         r_fall <= 1'b0;
      end else begin
         r_rise <= w_accept &&  r_s2;
         r_fall <= w_accept && !r_s2;
      end
   end

   assign rise = r_rise;
   assign fall = r_fall;
`else
   assign rise = 1'b0;
   assign fall = 1'b0;
`endif

endmodule : debounce_chan
`default_nettype wire

// File: rtl/input_debounce.sv
`default_nettype none
// ============================================================================
// Module      : input_debounce
// Description : Multi-channel debouncer for mechanical board inputs. Each
//               channel is an independent debounce_chan; this level only
//               slices the buses.
// Ports       : clk     - system clock (100 MHz PLL clock)
//               a_reset - asynchronous active-high reset
//               din     - [WIDTH] raw pin levels, asynchronous to clk
//               dout    - [WIDTH] debounced registered levels
//               rise    - [WIDTH] one-cycle pulse on dout 0->1
//               fall    - [WIDTH] one-cycle pulse on dout 1->0
// Macro       : INPUT_DEBOUNCE_EDGE_EN - enables the rise/fall registers;
//               when undefined rise/fall are constant 0, dout is unchanged.
// Revision    : 1.0 - initial release
// ============================================================================
module input_debounce
   import input_debounce_pkg::*;
#(
   parameter int               WIDTH         = 4,
   parameter int               STABLE_CYCLES = DEBOUNCE_10MS_100MHZ,
   parameter logic [WIDTH-1:0] RESET_VAL     = {WIDTH{1'b0}}
) (
   input  logic             clk,
   input  logic             a_reset,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic [WIDTH-1:0] rise,
   output logic [WIDTH-1:0] fall
);

   for (genvar g = 0; g < WIDTH; g++) begin : g_chan
      debounce_chan #(
         .STABLE_CYCLES (STABLE_CYCLES),
         .RESET_VAL     (RESET_VAL[g])
      ) u_chan (
         .clk     (clk),
         .a_reset (a_reset),
         .din     (din[g]),
         .dout    (dout[g]),
         .rise    (rise[g]),
         .fall    (fall[g])
      );
   end

endmodule : input_debounce
`default_nettype wire

// File: tb/tb_input_debounce.sv
`default_nettype none
// ============================================================================
// Module      : tb_input_debounce
// Description : Scoreboard bench for input_debounce (WIDTH=4, STABLE_CYCLES=8,
//               RESET_VAL=0). Stimulus pushes each expected output change
//               (edge number, dout, rise, fall); a monitor pops and compares
//               whenever the outputs change or a pulse appears.
// Macro       : INPUT_DEBOUNCE_EDGE_EN - when undefined, expected pulses are 0.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_input_debounce;

   localparam int c_stable = 8;
`ifdef INPUT_DEBOUNCE_EDGE_EN
   localparam bit c_edge_en = 1'b1;
`else
   localparam bit c_edge_en = 1'b0;
`endif

   typedef struct {
      int         edge_no;
      logic [3:0] dout;
      logic [3:0] rise;
      logic [3:0] fall;
   } exp_t;

   logic       clk;
   logic       a_reset;
   logic [3:0] din;
   logic [3:0] dout;
   logic [3:0] rise;
   logic [3:0] fall;

   exp_t       sb_q[$];
   int         n_pass;
   int         n_total;
   int         edge_cnt;
   logic [3:0] prev_dout;

   input_debounce #(
      .WIDTH         (4),
      .STABLE_CYCLES (c_stable),
      .RESET_VAL     (4'h0)
   ) dut (
      .clk     (clk),
      .a_reset (a_reset),
      .din     (din),
      .dout    (dout),
      .rise    (rise),
      .fall    (fall)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial edge_cnt = 0;
   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   // Called at a negedge right after din changes: the first following posedge
   // is the new level's edge 0, so the change lands STABLE_CYCLES+1 edges later.
   task automatic expect_change(input logic [3:0] d, input logic [3:0] r,
                                input logic [3:0] f);
      exp_t e;
      e.edge_no = edge_cnt + 1 + c_stable + 1;
      e.dout    = d;
      e.rise    = c_edge_en ? r : 4'h0;
      e.fall    = c_edge_en ? f : 4'h0;
      sb_q.push_back(e);
   endtask

   task automatic check_outs(input string name, input logic [11:0] exp_v);
      n_total++;
      if ({dout, rise, fall} === exp_v) n_pass++;
      else $display("FAIL %s: dout/rise/fall got %h/%h/%h, required %h/%h/%h",
                    name, dout, rise, fall, exp_v[11:8], exp_v[7:4], exp_v[3:0]);
   endtask

   task automatic check_drained(input string name);
      n_total++;
      if (sb_q.size() == 0) n_pass++;
      else $display("FAIL %s: %0d expected changes never appeared (next at edge %0d), required 0",
                    name, sb_q.size(), sb_q[0].edge_no);
   endtask

   // Monitor: any dout change or nonzero pulse is an output event.
   initial prev_dout = 4'h0;
   always @(posedge clk) begin
      exp_t e;
      #1;
      if (a_reset) begin
         prev_dout = dout;
      end else if (dout !== prev_dout || rise !== 4'h0 || fall !== 4'h0) begin
         n_total++;
         if (sb_q.size() == 0) begin
            $display("FAIL unexpected_event: edge %0d dout/rise/fall got %h/%h/%h, required no change",
                     edge_cnt, dout, rise, fall);
         end else begin
            e = sb_q.pop_front();
            if (edge_cnt == e.edge_no && dout === e.dout && rise === e.rise && fall === e.fall)
               n_pass++;
            else
               $display("FAIL event: got edge %0d dout/rise/fall %h/%h/%h, required edge %0d %h/%h/%h",
                        edge_cnt, dout, rise, fall, e.edge_no, e.dout, e.rise, e.fall);
         end
         prev_dout = dout;
      end
   end

   initial begin
      n_pass  = 0;
      n_total = 0;
      a_reset = 1'b1;
      din     = 4'hF;

      // 1: reset holds outputs low even with all pins high; quiet after release
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check_outs("reset_hold", 12'h000);
      end
      @(negedge clk);
      a_reset = 1'b0;
      din     = 4'h0;
      repeat (50) @(negedge clk);
      check_drained("t1_quiet");
      check_outs("t1_idle", 12'h000);

      // 2: single channel rises at edge STABLE_CYCLES+1
      din[0] = 1'b1;
      expect_change(4'b0001, 4'b0001, 4'b0000);
      repeat (14) @(negedge clk);
      check_drained("t2_rise0");

      // 3: bouncing shorter than STABLE_CYCLES is rejected, final hold accepted
      for (int k = 0; k < 10; k++) begin
         din[1] = ~din[1];
         repeat (3) @(negedge clk);
      end
      din[1] = 1'b1;
      expect_change(4'b0011, 4'b0010, 4'b0000);
      repeat (14) @(negedge clk);
      check_drained("t3_bounce");

      // 4: one cycle short of qualification never reaches dout
      din[2] = 1'b1;
      repeat (7) @(negedge clk);
      din[2] = 1'b0;
      repeat (15) @(negedge clk);
      check_drained("t4_short");
      check_outs("t4_level", 12'h300);

      // 5: raise channel 3, then drop channels 0 and 3 together
      din[3] = 1'b1;
      expect_change(4'b1011, 4'b1000, 4'b0000);
      repeat (14) @(negedge clk);
      check_drained("t5_rise3");
      din[3] = 1'b0;
      din[0] = 1'b0;
      expect_change(4'b0010, 4'b0000, 4'b1001);
      repeat (14) @(negedge clk);
      check_drained("t5_fall03");

      // 6: asynchronous reset mid-qualification (cnt = 5 after 7 edges)
      din[0] = 1'b1;
      repeat (7) @(posedge clk);
      #2;
      a_reset = 1'b1;
      #1;
      check_outs("t6_async_reset", 12'h000);
      repeat (3) @(negedge clk);
      check_outs("t6_reset_hold", 12'h000);
      a_reset = 1'b0;
      expect_change(4'b0011, 4'b0011, 4'b0000);
      repeat (14) @(negedge clk);
      check_drained("t6_requalify");
      check_outs("t6_level", 12'h300);

      repeat (5) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule : tb_input_debounce
`default_nettype wire
